// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bundle: ALU/load writeback channels, decode
// scoreboard ports and the registered register-file write port.
// master: the pipeline side (requesters, decode, register file).
// slave:  the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      alu_valid;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]     alu_data;
  logic                      alu_ready;
  logic                      ld_valid;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;
  logic [DATA_WIDTH-1:0]     ld_data;
  logic                      ld_ready;
  logic                      alloc_valid;
  logic [REG_ADDR_WIDTH-1:0] alloc_reg;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic                      stall;
  logic                      regwrite;
  logic [REG_ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0]     write_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output alloc_valid, alloc_reg, rs1, rs2,
    input  stall, regwrite, write_reg, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  alloc_valid, alloc_reg, rs1, rs2,
    output stall, regwrite, write_reg, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto one registered RF write port
// and tracks pending destinations. Ports: clock, reset (async,
// active-low), wb (regfile_wb_arbiter_if.slave).
// WB_ROUND_ROBIN_EN: round-robin on conflict; else ALU priority.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic clock,
  input logic reset,
  regfile_wb_arbiter_if.slave wb
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;

  typedef logic [REG_ADDR_WIDTH-1:0] ra_t;
  typedef logic [DATA_WIDTH-1:0]     dat_t;

  logic            alu_gnt;
  logic            ld_gnt;
  logic            xfer;
  ra_t             sel_rd;
  dat_t            sel_data;
  logic            regwrite_q, regwrite_d;
  ra_t             write_reg_q, write_reg_d;
  dat_t            write_data_q, write_data_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] set_m, clr_m;

`ifdef WB_ROUND_ROBIN_EN
  // ld_prio_q=1: the load unit wins the next conflict.
  logic ld_prio_q, ld_prio_d;

  always_comb begin
    alu_gnt   = wb.alu_valid & ~(wb.ld_valid & ld_prio_q);
    ld_gnt    = wb.ld_valid & ~(wb.alu_valid & ~ld_prio_q);
    ld_prio_d = ld_prio_q;
    if (alu_gnt) begin
      ld_prio_d = 1'b1;
    end else if (ld_gnt) begin
      ld_prio_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_prio_q <= 1'b0;
    end else begin
      ld_prio_q <= ld_prio_d;
    end
  end
`else
  always_comb begin
    alu_gnt = wb.alu_valid;
    ld_gnt  = wb.ld_valid & ~wb.alu_valid;
  end
`endif

  always_comb begin
    xfer     = alu_gnt | ld_gnt;
    sel_rd   = ld_gnt ? wb.ld_rd : wb.alu_rd;
    sel_data = ld_gnt ? wb.ld_data : wb.alu_data;
    // x0 writes are consumed but never reach the register file,
    // and the write port keeps its last index/data.
    regwrite_d   = xfer && (sel_rd != '0);
    write_reg_d  = regwrite_d ? sel_rd : write_reg_q;
    write_data_d = regwrite_d ? sel_data : write_data_q;
  end

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (wb.alloc_valid && (wb.alloc_reg != '0)) begin
      set_m[wb.alloc_reg] = 1'b1;
    end
    if (regwrite_q) begin
      clr_m[write_reg_q] = 1'b1;
    end
    // OR-ing set last lets a same-edge alloc win over the clear.
    pend_d = (pend_q & ~clr_m) | set_m;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pend_q       <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pend_q       <= pend_d;
    end
  end

  always_comb begin
    wb.alu_ready  = alu_gnt;
    wb.ld_ready   = ld_gnt;
    wb.regwrite   = regwrite_q;
    wb.write_reg  = write_reg_q;
    wb.write_data = write_data_q;
    wb.stall      = ((wb.rs1 != '0) && pend_q[wb.rs1]) ||
                    ((wb.rs2 != '0) && pend_q[wb.rs2]);
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes queued
// at grant time, popped when the write port should show them.
module tb_regfile_wb_arbiter;
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_pass;

  wr_t         sbq[$];
  logic [31:0] m_pend;
  logic        m_ldprio;
  logic        last_ag;
  logic        last_lg;

  regfile_wb_arbiter_if #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5)
  ) wb ();

  regfile_wb_arbiter #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wb(wb)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    wr_t         e;
    wr_t         n;
    logic        ag;
    logic        lg;
    logic        cur_we;
    logic [4:0]  cur_rd;
    logic [31:0] clr;
    logic [31:0] set;
    logic        exp_stall;
    @(negedge clock);
    cur_we = 1'b0;
    cur_rd = '0;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("regwrite", wb.regwrite, e.we);
      if (e.we) begin
        chk("write_reg", wb.write_reg, e.rd);
        chk("write_data", wb.write_data, e.data);
      end
      cur_we = e.we;
      cur_rd = e.rd;
    end
`ifdef WB_ROUND_ROBIN_EN
    if (wb.alu_valid && wb.ld_valid) begin
      ag = !m_ldprio;
      lg = m_ldprio;
    end else begin
      ag = wb.alu_valid;
      lg = wb.ld_valid;
    end
    if (ag) m_ldprio = 1'b1;
    else if (lg) m_ldprio = 1'b0;
`else
    ag = wb.alu_valid;
    lg = wb.ld_valid && !wb.alu_valid;
`endif
    chk("alu_ready", wb.alu_ready, ag);
    chk("ld_ready", wb.ld_ready, lg);
    n = '0;
    if (ag) begin
      n.rd   = wb.alu_rd;
      n.data = wb.alu_data;
    end else if (lg) begin
      n.rd   = wb.ld_rd;
      n.data = wb.ld_data;
    end
    n.we = (ag || lg) && (n.rd != 0);
    sbq.push_back(n);
    exp_stall = ((wb.rs1 != 0) && m_pend[wb.rs1]) ||
                ((wb.rs2 != 0) && m_pend[wb.rs2]);
    chk("stall", wb.stall, exp_stall);
    clr = '0;
    set = '0;
    if (cur_we) clr[cur_rd] = 1'b1;
    if (wb.alloc_valid && wb.alloc_reg != 0) set[wb.alloc_reg] = 1'b1;
    last_ag = ag;
    last_lg = lg;
    @(posedge clock);
    m_pend = (m_pend & ~clr) | set;
    #1;
  endtask

  task automatic idle_in();
    wb.alu_valid   = 1'b0;
    wb.ld_valid    = 1'b0;
    wb.alloc_valid = 1'b0;
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    n_chk = 0;
    n_pass = 0;
    m_pend = '0;
    m_ldprio = 1'b0;
    last_ag = 1'b0;
    last_lg = 1'b0;
    wb.alu_valid = 1'b0;
    wb.alu_rd = '0;
    wb.alu_data = '0;
    wb.ld_valid = 1'b0;
    wb.ld_rd = '0;
    wb.ld_data = '0;
    wb.alloc_valid = 1'b0;
    wb.alloc_reg = '0;
    wb.rs1 = 5'd5;
    wb.rs2 = 5'd9;

    #3;
    chk("rst_regwrite", wb.regwrite, 1'b0);
    chk("rst_write_reg", wb.write_reg, 5'd0);
    chk("rst_write_data", wb.write_data, 32'd0);
    chk("rst_stall", wb.stall, 1'b0);

    @(posedge clock);
    #1;
    reset = 1'b1;
    wb.rs1 = '0;
    wb.rs2 = '0;
    wb.alu_valid = 1'b1;
    wb.alu_rd = 5'd1;
    wb.alu_data = 32'd30;
    cyc();
    idle_in();
    cyc();

    wb.ld_valid = 1'b1;
    wb.ld_rd = 5'd0;
    wb.ld_data = 32'd20;
    cyc();
    idle_in();
    cyc();
    chk("x0_hold_reg", wb.write_reg, 5'd1);
    chk("x0_hold_data", wb.write_data, 32'd30);

    wb.alu_valid = 1'b1;
    wb.alu_rd = 5'd2;
    wb.alu_data = 32'hA;
    wb.ld_valid = 1'b1;
    wb.ld_rd = 5'd3;
    wb.ld_data = 32'hB;
    repeat (4) cyc();
    idle_in();
    cyc();

    wb.alloc_valid = 1'b1;
    wb.alloc_reg = 5'd5;
    cyc();
    idle_in();
    wb.rs1 = 5'd5;
    repeat (2) cyc();
    wb.alu_valid = 1'b1;
    wb.alu_rd = 5'd5;
    wb.alu_data = 32'd55;
    cyc();
    idle_in();
    repeat (2) cyc();
    chk("stall_clr5", wb.stall, 1'b0);
    wb.rs1 = '0;
    wb.alloc_valid = 1'b1;
    cyc();
    idle_in();
    cyc();
    wb.alu_valid = 1'b1;
    cyc();
    idle_in();
    repeat (2) cyc();

    wb.alloc_valid = 1'b1;
    wb.alloc_reg = 5'd7;
    wb.alu_valid = 1'b1;
    wb.alu_rd = 5'd7;
    wb.alu_data = 32'h77;
    cyc();
    wb.alu_valid = 1'b0;
    cyc();
    idle_in();
    wb.rs2 = 5'd7;
    cyc();
    chk("set_wins7", wb.stall, 1'b1);
    wb.alu_valid = 1'b1;
    cyc();
    idle_in();
    repeat (2) cyc();
    wb.rs2 = '0;

    for (int i = 0; i < 80; i++) begin
      if (!(wb.alu_valid && !last_ag)) begin
        wb.alu_valid = 1'($urandom_range(0, 1));
        wb.alu_rd = 5'($urandom_range(0, 31));
        wb.alu_data = $urandom;
      end
      if (!(wb.ld_valid && !last_lg)) begin
        wb.ld_valid = 1'($urandom_range(0, 1));
        wb.ld_rd = 5'($urandom_range(0, 31));
        wb.ld_data = $urandom;
      end
      wb.alloc_valid = 1'($urandom_range(0, 1));
      wb.alloc_reg = 5'($urandom_range(0, 31));
      wb.rs1 = 5'($urandom_range(0, 31));
      wb.rs2 = 5'($urandom_range(0, 31));
      cyc();
    end
    idle_in();
    repeat (2) cyc();

    wb.alu_valid = 1'b1;
    wb.alu_rd = 5'd4;
    wb.alu_data = 32'h44;
    wb.alloc_valid = 1'b1;
    wb.alloc_reg = 5'd4;
    cyc();
    idle_in();
    wb.rs1 = 5'd4;
    wb.rs2 = '0;
    #1;
    chk("pre_rst_we", wb.regwrite, 1'b1);
    chk("pre_rst_stall", wb.stall, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_kill_we", wb.regwrite, 1'b0);
    chk("rst_kill_reg", wb.write_reg, 5'd0);
    chk("rst_kill_stall", wb.stall, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    sbq.delete();
    m_pend = '0;
    m_ldprio = 1'b0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of write data.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register index width (32 registers).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_rd  input  REG_ADDR_WIDTH  ALU destination register.
REQ-007 alu_data  input  DATA_WIDTH  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle.
REQ-009 ld_valid, ld_rd, ld_data, ld_ready  same widths and directions as the ALU port; load-unit writeback channel.
REQ-010 alloc_valid  input  1  decode issues an instruction with a destination register.
REQ-011 alloc_reg  input  REG_ADDR_WIDTH  destination register being allocated.
REQ-012 rs1, rs2  input  REG_ADDR_WIDTH each  decode source registers.
REQ-013 stall  output  1  a source register has a pending write.
REQ-014 regwrite  output  1  register-file write enable.
REQ-015 write_reg  output  REG_ADDR_WIDTH  register-file write index.
REQ-016 write_data  output  DATA_WIDTH  register-file write data.

Function
REQ-017 Handshake: a transfer occurs in a cycle where valid=1 and ready=1; the requester holds rd and data stable while valid=1 and ready=0.
REQ-018 ready is combinational: at most one of alu_ready or ld_ready is 1 per cycle, and never while the corresponding valid=0.
REQ-019 With a single valid requester, that requester is granted the same cycle.
REQ-020 Write port is registered: a transfer in cycle N drives regwrite=1 with the accepted rd and data in cycle N+1; regwrite=0 in any cycle following a cycle without a transfer.
REQ-021 A transfer with rd=0 is accepted (ready=1) but drives regwrite=0 in cycle N+1, and write_reg/write_data hold their previous values.
REQ-022 Scoreboard: a 32-bit pending mask; an alloc with alloc_valid=1 and alloc_reg!=0 sets pending[alloc_reg] at the clock edge.
REQ-023 pending[r] clears at the edge where regwrite=1 and write_reg=r.
REQ-024 If set and clear hit the same register on the same edge, set wins.
REQ-025 stall = (rs1!=0 and pending[rs1]) or (rs2!=0 and pending[rs2]), combinational; register 0 never stalls.
REQ-026 Throughput: one write per cycle sustained; no bubble between back-to-back grants.

Reset
REQ-027 While reset=0: regwrite=0, write_reg=0, write_data=0, pending mask all 0, stall driven from the cleared mask, and priority pointer = ALU.
REQ-028 Reset asserted mid-transfer discards the in-flight write; it never reaches the register file after reset deasserts.
REQ-029 The first rising edge after reset deasserts behaves as a normal cycle.

Configuration
REQ-030 Macro WB_ROUND_ROBIN_EN defined: when both requesters are valid, grant goes to the requester not granted most recently. The pointer updates only on a transfer and starts at ALU priority after reset.
REQ-031 WB_ROUND_ROBIN_EN undefined: fixed priority. ALU always wins a conflict, and the load unit is granted only when alu_valid=0.

Verification
REQ-032 Reset released, alu_valid=1, alu_rd=1, alu_data=30 -> alu_ready=1 that cycle; next cycle regwrite=1, write_reg=1, write_data=30.
REQ-033 ld_valid=1, ld_rd=0, ld_data=20 -> ld_ready=1; next cycle regwrite=0 and pending mask unchanged.
REQ-034 Both valid for 4 cycles (rd 2/3, data 0xA/0xB), WB_ROUND_ROBIN_EN defined -> grants ALU, LD, ALU, LD; undefined -> ALU for all four cycles, ld_ready=0 throughout.
REQ-035 alloc_reg=5, then rs1=5 -> stall=1 until the edge where regwrite=1 with write_reg=5, then stall=0. The same case with rs1=0 -> stall=0.
REQ-036 Write to reg 7 completing on the same edge as alloc_reg=7 -> pending[7] remains 1 and stall=1 for rs2=7.
REQ-037 Pulse reset=0 for half a cycle one cycle after a grant of rd=4 -> regwrite=0 immediately, no write to reg 4 after release, pending mask 0.
